lcd_bus_responder: RTL and testbench
====================================

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles from data/RS valid to EN rise.
REQ-002 SHALL have parameter PULSE_CYC, default 25: EN high cycles.
REQ-003 SHALL have parameter HOLD_CYC, default 2: cycles data/RS held after EN fall.
REQ-004 SHALL have parameter WAIT_CYC, default 2000: settle cycles after a normal transfer.
REQ-005 SHALL have parameter LONG_WAIT_CYC, default 82000: settle cycles after clear (0x01) or home (0x02) commands.
REQ-006 SHALL have these ports, one clock; reset is asynchronous and active-high:
- i_clk  in  1  clock
- i_reset  in  1  async reset, active-high
- i_addr  in  32  LSU byte address
- i_wren  in  1  store strobe
- i_mask  in  4  byte enables
- i_stData  in  32  store data
- o_ldData  out  32  load data, combinational
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write, constant 0
- o_lcd_en  out  1  LCD enable strobe
- o_lcd_on  out  1  LCD power/backlight enable

Function
REQ-007 SHALL select the block only when i_addr[31:24]==8'h14; i_addr[2]==0 selects CMD, i_addr[2]==1 selects CTRL; other address bits are ignored.
REQ-008 A CMD store with i_mask[0]=1 SHALL push {rs, data} into a 4-entry FIFO: data=i_stData[7:0]; rs=i_stData[8] if i_mask[1]=1, else 0. A CMD store with i_mask[0]=0 SHALL be ignored.
REQ-009 A push while the FIFO is full and no pop occurs in the same cycle SHALL be dropped and SHALL set sticky overflow.
REQ-010 A push and a pop in the same cycle SHALL leave count unchanged and SHALL be accepted even when the FIFO is full.
REQ-011 A CTRL store with i_mask[0]=1 SHALL set lcd_on=i_stData[0] and SHALL clear overflow if i_stData[1]=1. If a clear and an overflow occur in the same cycle, overflow SHALL remain set.
REQ-012 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-013 IDLE with FIFO non-empty SHALL pop the head entry, latch it onto o_lcd_data/o_lcd_rs, and enter SETUP in the same edge.
REQ-014 SETUP SHALL last SETUP_CYC cycles and then enter PULSE. PULSE SHALL last PULSE_CYC cycles with o_lcd_en=1 and then enter HOLD. HOLD SHALL last HOLD_CYC cycles and then enter WAIT.
REQ-015 WAIT SHALL last LONG_WAIT_CYC cycles if the latched rs=0 and data is 0x01 or 0x02, otherwise WAIT_CYC cycles, and then enter IDLE.
REQ-016 o_lcd_en SHALL be registered and high only in PULSE. o_lcd_data/o_lcd_rs SHALL be stable from SETUP entry to WAIT exit.
REQ-017 A single counter SHALL time all states, sized for LONG_WAIT_CYC. It SHALL load N-1 on state entry and advance the state at 0.
REQ-018 The FIFO and the transfer FSM SHALL run regardless of lcd_on.
REQ-019 CTRL read SHALL return: [0]=lcd_on, [1]=overflow, [2]=busy (FSM!=IDLE or count!=0), [3]=full, [6:4]=count (0..4), other bits 0.
REQ-020 CMD read SHALL return {23'b0, rs, data} of the last latched transfer.
REQ-021 o_ldData SHALL be zero when the block is not selected, and byte lane k SHALL be zero when i_mask[k]=0.
REQ-022 o_lcd_rw SHALL be 0 at all times.

Reset
REQ-023 While i_reset=1, asynchronously: FIFO empty, count=0, overflow=0, lcd_on=0, FSM=IDLE, counter=0, last-transfer register=0.
REQ-024 During reset all outputs SHALL be 0, including o_lcd_en=0 immediately even if reset asserts mid-PULSE.
REQ-025 After reset release, no transfer SHALL start until a new push occurs.

Verification
(Benches use SETUP=2, PULSE=4, HOLD=2, WAIT=5, LONG_WAIT=20.)
REQ-026 Store 0x0000_0141 with mask 4'b0011 to 0x1400_0000 -> one EN pulse, 4 cycles wide; data=0x41, rs=1; busy returns to 0 after 2+4+2+5 cycles plus 1 cycle of IDLE pop.
REQ-027 Store 0x01 with mask 4'b0001 -> rs=0; WAIT lasts 20 cycles; CMD read returns 0x0000_0001.
REQ-028 Six back-to-back CMD stores while busy -> first pops immediately, next four fill the FIFO, sixth is dropped; CTRL read shows overflow=1, full=1, count=4; exactly five EN pulses follow.
REQ-029 CTRL store 0x3 -> lcd_on=1 and overflow cleared; CTRL load with mask 4'b0001 returns 0x01; load from 0x1500_0004 returns 0.
REQ-030 Assert i_reset during PULSE -> o_lcd_en=0 the same cycle; FIFO empty; no further pulses after release.
REQ-031 Push in the same cycle as an IDLE pop with FIFO full -> entry accepted, overflow stays 0, count stays 4.

Source files
------------

// File: rtl/lcd_bus_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_bus_responder: LSU-mapped HD44780-style LCD write port with a    |
// | 4-entry command FIFO and a timed SETUP/PULSE/HOLD/WAIT strobe FSM.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd_bus_responder #(
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 25,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic        i_wren,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_stData,
  output logic [31:0] o_ldData,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int c_max_a   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int c_max_b   = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int c_max_c   = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_max_cyc = (c_max_c > LONG_WAIT_CYC) ? c_max_c : LONG_WAIT_CYC;
  localparam int c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;

  // The counter holds N-1 on entry, so log2(max N) bits are enough.
  localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_pulse_ld = c_cnt_w'(PULSE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(HOLD_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_wait_ld  = c_cnt_w'(WAIT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_long_ld  = c_cnt_w'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;

  logic [8:0]  r_fifo [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_ovf;
  logic        r_on;
  logic        r_en;
  logic [8:0]  r_last;

  logic        w_sel;
  logic        w_push;
  logic        w_ctrl_wr;
  logic        w_pop;
  logic        w_full;
  logic        w_accept;
  logic        w_ovf_set;
  logic        w_busy;
  logic        w_long;
  logic [8:0]  w_entry;
  logic [31:0] w_ctrl_rd;
  logic [31:0] w_cmd_rd;
  logic [31:0] w_rd_raw;
  logic        w_unused;

  assign w_sel     = (i_addr[31:24] == 8'h14);
  assign w_push    = w_sel && i_wren && !i_addr[2] && i_mask[0];
  assign w_ctrl_wr = w_sel && i_wren && i_addr[2] && i_mask[0];
  assign w_pop     = (r_state == ST_IDLE) && (r_count != 3'd0);
  assign w_full    = (r_count == 3'd4);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_accept  = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_busy    = (r_state != ST_IDLE) || (r_count != 3'd0);
  assign w_entry   = {i_mask[1] & i_stData[8], i_stData[7:0]};
  assign w_long    = !r_last[8] && ((r_last[7:0] == 8'h01) || (r_last[7:0] == 8'h02));
  assign w_unused  = ^{i_addr[23:3], i_addr[1:0], i_stData[31:9]};

  // Entry storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_fifo[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      r_ovf    <= 1'b0;
      r_on     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_ctrl_wr) begin
        r_on <= i_stData[0];
      end
      // A fresh overflow wins over a software clear in the same cycle.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ctrl_wr && i_stData[1]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_last  <= 9'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= (w_state_nxt == ST_PULSE);
      if (w_pop) begin
        r_last <= r_fifo[r_rd_ptr];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = c_setup_ld;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = c_pulse_ld;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_hold_ld;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = w_long ? c_long_ld : c_wait_ld;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_ctrl_rd = {25'd0, r_count, w_full, w_busy, r_ovf, r_on};
  assign w_cmd_rd  = {23'd0, r_last};
  assign w_rd_raw  = i_addr[2] ? w_ctrl_rd : w_cmd_rd;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign o_ldData[8*k +: 8] = (w_sel && i_mask[k]) ? w_rd_raw[8*k +: 8] : 8'h00;
  end

  assign o_lcd_data = r_last[7:0];
  assign o_lcd_rs   = r_last[8];
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_en;
  assign o_lcd_on   = r_on;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_bus_responder: directed + random bench against a queue model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lcd_bus_responder;

  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 2;
  localparam int W = 5;
  localparam int L = 20;

  localparam logic [31:0] c_cmd  = 32'h1400_0000;
  localparam logic [31:0] c_ctrl = 32'h1400_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wren;
  logic [3:0]  mask;
  logic [31:0] st;
  logic [31:0] ld;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;

  lcd_bus_responder #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .WAIT_CYC(W), .LONG_WAIT_CYC(L)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_wren(wren), .i_mask(mask),
    .i_stData(st), .o_ldData(ld), .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_on(lcd_on)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  bit prev_en  = 1'b0;

  // Reference model: a queue of pending writes plus one transfer timeline.
  bit [8:0] q[$];
  bit       m_ovf, m_on, m_act;
  bit [8:0] m_last;
  int       m_t, m_dur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_on = 0; m_act = 0; m_last = '0; m_t = 0; m_dur = 0;
  endtask

  function automatic bit exp_en();
    return m_act && (m_t >= S) && (m_t < S + P);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] v;
    int          n;
    n = q.size();
    if (a[31:24] != 8'h14) return 32'd0;
    if (a[2])
      v = 32'(n * 16 + ((n == 4) ? 8 : 0) + ((m_act || n != 0) ? 4 : 0) +
              (m_ovf ? 2 : 0) + (m_on ? 1 : 0));
    else
      v = {23'd0, m_last};
    for (int k = 0; k < 4; k++)
      if (!m[k]) v[8*k +: 8] = 8'h00;
    return v;
  endfunction

  task automatic model_edge();
    bit do_pop, push, ctrlw, ovf_set;
    int sz;
    if (rst) begin
      model_reset();
      return;
    end
    sz      = q.size();
    do_pop  = !m_act && (sz > 0);
    push    = wren && (addr[31:24] == 8'h14) && !addr[2] && mask[0];
    ctrlw   = wren && (addr[31:24] == 8'h14) && addr[2] && mask[0];
    ovf_set = push && (sz == 4) && !do_pop;
    if (m_act) begin
      m_t++;
      if (m_t == m_dur) m_act = 0;
    end
    if (do_pop) begin
      m_last = q.pop_front();
      m_act  = 1;
      m_t    = 0;
      m_dur  = S + P + H +
               ((!m_last[8] && (m_last[7:0] == 8'h01 || m_last[7:0] == 8'h02)) ? L : W);
    end
    if (push && !ovf_set) q.push_back({mask[1] & st[8], st[7:0]});
    if (ctrlw) begin
      m_on = st[0];
      if (st[1]) m_ovf = 0;
    end
    if (ovf_set) m_ovf = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("lcd_en", lcd_en, exp_en());
    check("lcd_data", lcd_data, m_last[7:0]);
    check("lcd_rs", lcd_rs, m_last[8]);
    check("lcd_rw", lcd_rw, 0);
    check("lcd_on", lcd_on, m_on);
    check("ldData", ld, exp_rd(addr, mask));
    if (lcd_en && !prev_en) pulses++;
    prev_en = lcd_en;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    addr = a; mask = m; st = d; wren = 1'b1;
    step();
    wren = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [3:0] m,
                            input logic [31:0] want);
    addr = a; mask = m; wren = 1'b0;
    #1;
    check(tag, ld, want);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((m_act || q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    check(tag, 32'(n < 400), 1);
  endtask

  task automatic busy_run(input int limit, output int n, output int en_cycles);
    n = 0; en_cycles = 0;
    addr = c_ctrl; mask = 4'hF;
    do begin
      step();
      n++;
      if (lcd_en) en_cycles++;
    end while (ld[2] && n < limit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, en_cycles;
    rst = 1'b1; addr = 32'd0; wren = 1'b0; mask = 4'h0; st = 32'd0;
    model_reset();
    repeat (3) step();
    read_check("reset_ctrl", c_ctrl, 4'hF, 32'd0);
    read_check("reset_cmd", c_cmd, 4'hF, 32'd0);
    check("reset_en", lcd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single data write: rs=1, 4-cycle pulse, 14-cycle busy window.
    pulses = 0;
    bus_write(c_cmd, 4'b0011, 32'h0000_0141);
    busy_run(100, n, en_cycles);
    check("t1_busy_len", n, 14);
    check("t1_en_width", en_cycles, 4);
    check("t1_pulses", pulses, 1);
    check("t1_data", lcd_data, 8'h41);
    check("t1_rs", lcd_rs, 1);

    // Clear-display command uses the long wait.
    bus_write(c_cmd, 4'b0001, 32'h0000_0101);
    busy_run(100, n, en_cycles);
    check("t2_busy_len", n, 1 + S + P + H + L);
    check("t2_rs", lcd_rs, 0);
    read_check("t2_cmd_rd", c_cmd, 4'hF, 32'h0000_0001);

    // Six back-to-back pushes: one pops, four queue, one overflows.
    pulses = 0;
    for (int i = 0; i < 6; i++) bus_write(c_cmd, 4'b0011, 32'h100 | (32'h30 + i));
    read_check("t3_ctrl", c_ctrl, 4'hF, 32'h0000_004E);
    drain("t3_drain");
    check("t3_pulses", pulses, 5);

    // Control write sets lcd_on and clears overflow.
    bus_write(c_ctrl, 4'b0001, 32'h0000_0003);
    read_check("t4_ctrl_lane0", c_ctrl, 4'b0001, 32'h0000_0001);
    read_check("t4_unselected", 32'h1500_0004, 4'hF, 32'd0);
    read_check("t4_masked", c_ctrl, 4'b1110, 32'd0);
    check("t4_on_pin", lcd_on, 1);

    // Push lands on the same edge as the IDLE pop of a full FIFO.
    bus_write(c_cmd, 4'b0001, 32'h55);
    for (int i = 0; i < 4; i++) bus_write(c_cmd, 4'b0001, 32'h60 + i);
    n = 0;
    while (m_act && n < 100) begin step(); n++; end
    check("t5_full_before", 32'(q.size()), 4);
    bus_write(c_cmd, 4'b0001, 32'h77);
    read_check("t5_ctrl", c_ctrl, 4'hF, 32'h0000_004D);
    drain("t5_drain");

    // Reset in the middle of a pulse.
    bus_write(c_cmd, 4'b0011, 32'h133);
    n = 0;
    while (!(m_act && m_t == S + 1) && n < 50) begin step(); n++; end
    check("t6_en_before", lcd_en, 1);
    addr = c_ctrl; mask = 4'hF;
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_en_async", lcd_en, 0);
    check("t6_data_async", lcd_data, 0);
    check("t6_on_async", lcd_on, 0);
    check("t6_ld_async", ld, 0);
    repeat (2) step();
    rst = 1'b0;
    pulses = 0;
    repeat (40) step();
    check("t6_no_pulse", pulses, 0);
    read_check("t6_ctrl", c_ctrl, 4'hF, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [7:0] hb;
      r    = $urandom_range(0, 99);
      mask = 4'($urandom);
      st   = $urandom;
      wren = 1'b0;
      if ($urandom_range(0, 3) == 0) st[7:0] = 8'($urandom_range(1, 2));
      if (r < 5) begin
        wren = 1'b1;
        addr = {8'h14, 24'($urandom)} & ~32'h4;
        if ($urandom_range(0, 4) != 0) mask[0] = 1'b1;
      end else if (r < 7) begin
        wren = 1'b1;
        addr = {8'h14, 24'($urandom)} | 32'h4;
      end else begin
        hb = 8'($urandom);
        if (hb == 8'h14) hb = 8'h15;
        wren = (r < 10);
        addr = (r < 12) ? {hb, 24'($urandom)} : {8'h14, 24'($urandom)};
      end
      step();
    end
    wren = 1'b0;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
